// File: rtl/am2q_share_compressor.sv
// am2q_share_compressor
// Receiving end of the masked PRINCE S-box coordinate functions. Nine partial
// shares per coordinate are captured in a glitch-barrier register (stage 1),
// then XOR-compressed three-to-one into three output shares (stage 2).
// Both stages use a valid/ready elastic handshake.
//
// Handshake: a word moves across a boundary on a rising clock edge where
// valid && ready are both high. Valid, once raised, stays high and its data
// stays stable until the word is taken. i_in_ready depends combinationally on
// i_out_ready. While i_rst is high, o_in_ready is held low.
//
// Optional build macro: AM2Q_UNMASK_DEBUG_EN adds o_out_unmasked (the
// recombined value) and a 16-bit output-handshake counter o_dbg_count.
// These are for simulation/verification builds only. Without the macro no
// recombined value exists anywhere in the netlist.
module am2q_share_compressor #(
   parameter int NCOORD = 4,
   parameter int NPART  = 9
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [NCOORD*NPART-1:0] i_in_parts,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [NCOORD-1:0]       o_out_share0,
   output logic [NCOORD-1:0]       o_out_share1,
`ifdef AM2Q_UNMASK_DEBUG_EN
   output logic [NCOORD-1:0]       o_out_share2,
   output logic [NCOORD-1:0]       o_out_unmasked,
   output logic [15:0]             o_dbg_count
`else
   output logic [NCOORD-1:0]       o_out_share2
`endif
);

   // Stage 1: raw partials; no logic between the input and this register.
   logic [NCOORD*NPART-1:0] r_p1;
   logic                    r_v1;
   // Stage 2: compressed shares.
   logic [NCOORD-1:0]       r_sh0;
   logic [NCOORD-1:0]       r_sh1;
   logic [NCOORD-1:0]       r_sh2;
   logic                    r_v2;

   logic                    w_s2_accept;
   logic                    w_s1_adv;
   logic                    w_in_ready;
   logic                    w_in_acc;
   logic [NCOORD-1:0]       w_c0;
   logic [NCOORD-1:0]       w_c1;
   logic [NCOORD-1:0]       w_c2;

   // Pipeline handshake: a stage accepts when empty or when it drains this cycle.
   always_comb begin
      w_s2_accept = !r_v2 || i_out_ready;
      w_s1_adv    = r_v1 && w_s2_accept;
      w_in_ready  = !i_rst && (!r_v1 || w_s1_adv);
      w_in_acc    = i_in_valid && w_in_ready;
   end

   // Three-to-one compression, taken only from registered partials.
   always_comb begin
      w_c0 = '0;
      w_c1 = '0;
      w_c2 = '0;
      for (int k = 0; k < NCOORD; k++) begin
         w_c0[k] = r_p1[NPART*k+0] ^ r_p1[NPART*k+1] ^ r_p1[NPART*k+2];
         w_c1[k] = r_p1[NPART*k+3] ^ r_p1[NPART*k+4] ^ r_p1[NPART*k+5];
         w_c2[k] = r_p1[NPART*k+6] ^ r_p1[NPART*k+7] ^ r_p1[NPART*k+8];
      end
   end

   // Stage 1 register: loads partials on an accepted input; data holds otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1 <= 1'b0;
         r_p1 <= '0;
      end else begin
         r_v1 <= w_in_acc || (r_v1 && !w_s1_adv);
         if (w_in_acc) begin
            r_p1 <= i_in_parts;
         end
      end
   end

   // Stage 2 register: loads compressed shares when stage 1 advances.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v2  <= 1'b0;
         r_sh0 <= '0;
         r_sh1 <= '0;
         r_sh2 <= '0;
      end else begin
         r_v2 <= w_s1_adv || (r_v2 && !i_out_ready);
         if (w_s1_adv) begin
            r_sh0 <= w_c0;
            r_sh1 <= w_c1;
            r_sh2 <= w_c2;
         end
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = r_v2;
   assign o_out_share0 = r_sh0;
   assign o_out_share1 = r_sh1;
   assign o_out_share2 = r_sh2;

`ifdef AM2Q_UNMASK_DEBUG_EN
   logic [15:0] r_dbg_count;

   // Output handshake counter; wraps naturally at 16 bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dbg_count <= '0;
      end else if (r_v2 && i_out_ready) begin
         r_dbg_count <= r_dbg_count + 16'd1;
      end
   end

   assign o_out_unmasked = r_sh0 ^ r_sh1 ^ r_sh2;
   assign o_dbg_count    = r_dbg_count;
`endif

endmodule

// File: tb/tb_am2q_share_compressor.sv
// tb_am2q_share_compressor
// Directed bench for am2q_share_compressor: hand-computed vector table,
// streaming, stall, mid-flight reset and (with AM2Q_UNMASK_DEBUG_EN) the
// debug counter wrap.
module tb_am2q_share_compressor;

   localparam int NC = 4;
   localparam int NP = 9;

   logic           i_clk;
   logic           i_rst;
   logic           i_in_valid;
   logic           o_in_ready;
   logic [NC*NP-1:0] i_in_parts;
   logic           o_out_valid;
   logic           i_out_ready;
   logic [NC-1:0]  o_out_share0;
   logic [NC-1:0]  o_out_share1;
   logic [NC-1:0]  o_out_share2;
`ifdef AM2Q_UNMASK_DEBUG_EN
   logic [NC-1:0]  o_out_unmasked;
   logic [15:0]    o_dbg_count;
`endif

   am2q_share_compressor #(.NCOORD(NC), .NPART(NP)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_parts   (i_in_parts),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_out_share0 (o_out_share0),
      .o_out_share1 (o_out_share1),
`ifdef AM2Q_UNMASK_DEBUG_EN
      .o_out_share2 (o_out_share2),
      .o_out_unmasked (o_out_unmasked),
      .o_dbg_count  (o_dbg_count)
`else
      .o_out_share2 (o_out_share2)
`endif
   );

   // Clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [NC*NP-1:0] parts;
      logic [NC-1:0]    e0;
      logic [NC-1:0]    e1;
      logic [NC-1:0]    e2;
   } vec_t;

   vec_t        vecs[5];
   logic [11:0] exp_q[$];
   int          n_checks;
   int          n_errors;
   int          n_out;
   logic        prev_stall;
   logic [11:0] prev_sh;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: three-to-one XOR per coordinate, packed {s2,s1,s0}.
   function automatic logic [11:0] model(input logic [NC*NP-1:0] p);
      logic [NC-1:0] s0, s1, s2;
      for (int k = 0; k < NC; k++) begin
         s0[k] = p[9*k] ^ p[9*k+1] ^ p[9*k+2];
         s1[k] = p[9*k+3] ^ p[9*k+4] ^ p[9*k+5];
         s2[k] = p[9*k+6] ^ p[9*k+7] ^ p[9*k+8];
      end
      return {s2, s1, s0};
   endfunction

   function automatic logic [11:0] shares();
      return {o_out_share2, o_out_share1, o_out_share0};
   endfunction

   task automatic do_reset();
      i_rst = 1'b1;
      i_in_valid = 1'b0;
      i_out_ready = 1'b0;
      i_in_parts = '0;
      tick();
      tick();
      i_rst = 1'b0;
      #1;
      exp_q.delete();
      prev_stall = 1'b0;
   endtask

   // One cycle of scoreboarded traffic; sampling happens 2 time units after the edge.
   task automatic run_cycle(input logic iv, input logic [NC*NP-1:0] parts,
                            input logic ordy, output logic accepted);
      i_in_valid  = iv;
      i_in_parts  = parts;
      i_out_ready = ordy;
      #1;
      check("in_ready", {35'b0, o_in_ready}, {35'b0, !(exp_q.size() == 2 && !ordy)});
      if (prev_stall) begin
         check("hold_valid", {35'b0, o_out_valid}, 36'd1);
         check("hold_shares", {24'b0, shares()}, {24'b0, prev_sh});
      end
      if (o_out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 36'd1, 36'd0);
         end else begin
            check("stream_data", {24'b0, shares()}, {24'b0, exp_q.pop_front()});
         end
         n_out++;
      end
      accepted = iv && o_in_ready;
      if (accepted) exp_q.push_back(model(parts));
      prev_stall = o_out_valid && !ordy;
      prev_sh    = shares();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic             acc;
      int               w;
      int               out_hist[12];
      logic [NC*NP-1:0] words[10];

      n_checks = 0;
      n_errors = 0;
      n_out    = 0;
      prev_stall = 1'b0;
      prev_sh  = '0;

      // coord3 .. coord0, each 9 bits with partial 0 in the LSB
      vecs[0] = '{{9'h000, 9'h000, 9'h000, 9'b000_000_111}, 4'b0001, 4'b0000, 4'b0000};
      vecs[1] = '{{9'b110_010_001, 9'h000, 9'h000, 9'h000}, 4'b1000, 4'b1000, 4'b0000};
      vecs[2] = '{{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, 4'b1111, 4'b1111, 4'b1111};
      vecs[3] = '{{9'h000, 9'b100_001_010, 9'b011_101_110, 9'h000}, 4'b0100, 4'b0100, 4'b0100};
      vecs[4] = '{{9'h000, 9'h000, 9'b111_000_011, 9'b001_010_100}, 4'b0001, 4'b0001, 4'b0011};

      // Reset state
      do_reset();
      check("rst_out_valid", {35'b0, o_out_valid}, 36'd0);
      check("rst_in_ready", {35'b0, o_in_ready}, 36'd1);
      check("rst_shares", {24'b0, shares()}, 36'd0);

      // Vector table: single word, latency 2, hand-computed shares
      for (int i = 0; i < 5; i++) begin
         i_in_valid  = 1'b1;
         i_in_parts  = vecs[i].parts;
         i_out_ready = 1'b1;
         #1;
         check("vec_in_ready", {35'b0, o_in_ready}, 36'd1);
         tick();
         i_in_valid = 1'b0;
         #1;
         check("vec_t1_valid", {35'b0, o_out_valid}, 36'd0);
         tick();
         check("vec_t2_valid", {35'b0, o_out_valid}, 36'd1);
         check("vec_share0", {32'b0, o_out_share0}, {32'b0, vecs[i].e0});
         check("vec_share1", {32'b0, o_out_share1}, {32'b0, vecs[i].e1});
         check("vec_share2", {32'b0, o_out_share2}, {32'b0, vecs[i].e2});
`ifdef AM2Q_UNMASK_DEBUG_EN
         check("vec_unmasked", {32'b0, o_out_unmasked},
               {32'b0, vecs[i].e0 ^ vecs[i].e1 ^ vecs[i].e2});
`endif
         tick();
         check("vec_drained", {35'b0, o_out_valid}, 36'd0);
      end

      // Back-to-back stream of 8 words with out_ready high
      for (int i = 0; i < 10; i++) words[i] = {$urandom(), $urandom_range(0, 15)};
      do_reset();
      n_out = 0;
      w = 0;
      for (int c = 0; c < 12; c++) begin
         run_cycle(w < 8, words[w % 10], 1'b1, acc);
         if (acc) w++;
         out_hist[c] = n_out;
      end
      check("stream_none_at_t1", out_hist[1], 0);
      check("stream_first_at_t2", out_hist[2], 1);
      check("stream_all_by_t9", out_hist[9], 8);
      check("stream_accepted", w, 8);

      // Stall: out_ready low for 5 cycles while streaming 10 words
      for (int i = 0; i < 10; i++) words[i] = {$urandom(), $urandom_range(0, 15)};
      n_out = 0;
      w = 0;
      for (int c = 0; c < 30; c++) begin
         run_cycle(w < 10, words[w % 10], !(c >= 3 && c < 8), acc);
         if (acc) w++;
      end
      check("stall_out_count", n_out, 10);
      check("stall_queue_empty", exp_q.size(), 0);

      // Reset with both stages full
      words[0] = {$urandom(), 4'h5};
      words[1] = {$urandom(), 4'hA};
      run_cycle(1'b1, words[0], 1'b0, acc);
      run_cycle(1'b1, words[1], 1'b0, acc);
      run_cycle(1'b1, words[1] ^ 36'h1, 1'b0, acc);
      check("full_valid", {35'b0, o_out_valid}, 36'd1);
      i_rst = 1'b1;
      i_in_valid = 1'b1;
      #1;
      check("rst_forces_in_ready_low", {35'b0, o_in_ready}, 36'd0);
      tick();
      i_rst = 1'b0;
      i_in_valid = 1'b0;
      #1;
      check("midrst_out_valid", {35'b0, o_out_valid}, 36'd0);
      check("midrst_in_ready", {35'b0, o_in_ready}, 36'd1);
      check("midrst_shares", {24'b0, shares()}, 36'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      n_out = 0;
      for (int c = 0; c < 4; c++) run_cycle(1'b0, '0, 1'b1, acc);
      check("midrst_no_emit", n_out, 0);

`ifdef AM2Q_UNMASK_DEBUG_EN
      // Debug counter wraps after 65536 handshakes
      begin
         int hs;
         do_reset();
         check("dbg_rst", {20'b0, o_dbg_count}, 36'd0);
         hs = 0;
         i_in_valid  = 1'b1;
         i_in_parts  = '0;
         i_out_ready = 1'b1;
         for (int c = 0; c < 70000; c++) begin
            #1;
            if (o_out_valid && i_out_ready) hs++;
            tick();
            if (hs == 65537) break;
         end
         i_in_valid = 1'b0;
         check("dbg_hs_reached", hs, 65537);
         check("dbg_wrap", {20'b0, o_dbg_count}, 36'd1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
